// File: rtl/my_pkg.sv
`default_nettype none
// ============================================================================
// Package  : my_pkg
// Purpose  : Shared decode types, RV32I opcode constants and the NOP encoding.
// Revision : 1.0
// ============================================================================
package my_pkg;

  typedef enum logic [2:0] {R_type, I_type, S_type, B_type, U_type, J_type} fmts;
  typedef enum logic [2:0] {adder, logical, shifter, branch, memory, bypass} xu;
  typedef enum logic [2:0] {OP0, OP1, OP2, OP3, OP4, OP5, OP6, OP7} instruction_type;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // addi x0,x0,0
  localparam logic [31:0] NOP_WORD = 32'h00000013;

endpackage
`default_nettype wire

// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
// Interface : decode_stage_if
// Purpose   : Fetch-side inputs and operandFetch-side outputs of the decode stage.
// Revision  : 1.0
// ============================================================================
interface decode_stage_if;
  import my_pkg::*;

  logic [31:0]     instr_in;
  logic [31:0]     NPC_in;
  logic [3:0]      tag_in;
  logic            bubble;
  logic            jump;
  logic [31:0]     instruction;
  logic [31:0]     NPC_out;
  logic [3:0]      tag_out;
  fmts             fmt;
  xu               xu_sel;
  instruction_type i_out;
  logic            illegal;

  modport master (
    output instr_in, NPC_in, tag_in, bubble, jump,
    input  instruction, NPC_out, tag_out, fmt, xu_sel, i_out, illegal
  );

  modport slave (
    input  instr_in, NPC_in, tag_in, bubble, jump,
    output instruction, NPC_out, tag_out, fmt, xu_sel, i_out, illegal
  );

endinterface
`default_nettype wire

// File: rtl/rv32i_decoder.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_decoder
// Purpose  : Combinational RV32I decode of one word into format, unit and operation.
// Revision : 1.0
// ============================================================================
module rv32i_decoder
  import my_pkg::*;
(
  input  logic [31:0]     instr,
  output fmts             fmt,
  output xu               xu_sel,
  output instruction_type i_out,
  output logic            illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_r;
  logic       f7_zero;
  logic       f7_alt;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign is_r    = (opcode == OPC_OP);
  assign f7_zero = (instr[31:25] == 7'b0000000);
  assign f7_alt  = (instr[31:25] == 7'b0100000);

  always_comb begin
    fmt     = R_type;
    xu_sel  = bypass;
    i_out   = OP0;
    illegal = 1'b0;
    case (opcode)
      OPC_LUI:   begin fmt = U_type; xu_sel = bypass; i_out = OP1; end
      OPC_AUIPC: begin fmt = U_type; xu_sel = adder;  i_out = OP0; end
      OPC_JAL:   begin fmt = J_type; xu_sel = branch; i_out = OP6; end
      OPC_JALR: begin
        fmt = I_type; xu_sel = branch; i_out = OP7;
        illegal = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        fmt = B_type; xu_sel = branch;
        case (funct3)
          3'b000:  i_out = OP0;
          3'b001:  i_out = OP1;
          3'b100:  i_out = OP2;
          3'b101:  i_out = OP3;
          3'b110:  i_out = OP4;
          3'b111:  i_out = OP5;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        fmt = I_type; xu_sel = memory;
        case (funct3)
          3'b000:  i_out = OP0;
          3'b100:  i_out = OP1;
          3'b001:  i_out = OP2;
          3'b101:  i_out = OP3;
          3'b010:  i_out = OP4;
          default: illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        fmt = S_type; xu_sel = memory;
        case (funct3)
          3'b000:  i_out = OP5;
          3'b001:  i_out = OP6;
          3'b010:  i_out = OP7;
          default: illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM, OPC_OP: begin
        // funct7 is immediate data for OP-IMM except on the shift encodings
        fmt = is_r ? R_type : I_type;
        case (funct3)
          3'b000: begin
            xu_sel  = adder;
            i_out   = (is_r && f7_alt) ? OP1 : OP0;
            illegal = is_r && !(f7_zero || f7_alt);
          end
          3'b001: begin xu_sel = shifter; i_out = OP0; illegal = !f7_zero; end
          3'b010: begin xu_sel = adder;   i_out = OP2; illegal = is_r && !f7_zero; end
          3'b011: begin xu_sel = adder;   i_out = OP3; illegal = is_r && !f7_zero; end
          3'b100: begin xu_sel = logical; i_out = OP0; illegal = is_r && !f7_zero; end
          3'b101: begin
            xu_sel  = shifter;
            i_out   = f7_alt ? OP2 : OP1;
            illegal = !(f7_zero || f7_alt);
          end
          3'b110: begin xu_sel = logical; i_out = OP1; illegal = is_r && !f7_zero; end
          default: begin xu_sel = logical; i_out = OP2; illegal = is_r && !f7_zero; end
        endcase
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      fmt    = R_type;
      xu_sel = bypass;
      i_out  = OP0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Purpose  : Decode pipeline register with flush-to-NOP and bubble hold.
// Revision : 1.0
// ============================================================================
module decode_stage
  import my_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  decode_stage_if.slave  bus
);

  logic [31:0]     instr_q, instr_d;
  logic [31:0]     npc_q, npc_d;
  logic [3:0]      tag_q, tag_d;
  fmts             dec_fmt;
  xu               dec_xu;
  instruction_type dec_op;
  logic            dec_illegal;

  // Flush beats stall; bubble=0 means operandFetch is not accepting
  always_comb begin
    instr_d = instr_q;
    npc_d   = npc_q;
    tag_d   = tag_q;
    if (bus.jump) begin
      instr_d = NOP_WORD;
      npc_d   = 32'h0;
      tag_d   = bus.tag_in;
    end else if (bus.bubble) begin
      instr_d = bus.instr_in;
      npc_d   = bus.NPC_in;
      tag_d   = bus.tag_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q <= NOP_WORD;
      npc_q   <= 32'h0;
      tag_q   <= 4'h0;
    end else begin
      instr_q <= instr_d;
      npc_q   <= npc_d;
      tag_q   <= tag_d;
    end
  end

  rv32i_decoder u_decoder (
    .instr   (instr_q),
    .fmt     (dec_fmt),
    .xu_sel  (dec_xu),
    .i_out   (dec_op),
    .illegal (dec_illegal)
  );

  assign bus.instruction = dec_illegal ? NOP_WORD : instr_q;
  assign bus.NPC_out     = npc_q;
  assign bus.tag_out     = tag_q;
  assign bus.fmt         = dec_fmt;
  assign bus.xu_sel      = dec_xu;
  assign bus.i_out       = dec_op;
  assign bus.illegal     = dec_illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Purpose  : Directed self-checking bench for decode_stage.
// Revision : 1.0
// ============================================================================
module tb_decode_stage;
  import my_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  decode_stage_if bus ();

  decode_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_dec(input string tag, input fmts ef, input xu ex,
                           input instruction_type eo, input logic eil,
                           input logic [31:0] ein);
    check({tag, ".fmt"},     32'(bus.fmt),     32'(ef));
    check({tag, ".xu"},      32'(bus.xu_sel),  32'(ex));
    check({tag, ".op"},      32'(bus.i_out),   32'(eo));
    check({tag, ".illegal"}, 32'(bus.illegal), 32'(eil));
    check({tag, ".instr"},   bus.instruction,  ein);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vec(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                     input logic [6:0] f7, input fmts ef, input xu ex,
                     input instruction_type eo);
    logic [31:0] word;
    word = {f7, 5'd3, 5'd2, f3, 5'd1, opc};
    bus.instr_in = word;
    bus.bubble   = 1'b1;
    tick();
    check_dec(tag, ef, ex, eo, 1'b0, word);
  endtask

  task automatic ivec(input string tag, input logic [31:0] word);
    bus.instr_in = word;
    bus.bubble   = 1'b1;
    tick();
    check_dec(tag, R_type, bypass, OP0, 1'b1, NOP_WORD);
  endtask

  initial begin
    logic [31:0] w;
    logic [6:0]  opc;
    reset        = 1'b0;
    bus.instr_in = 32'h0;
    bus.NPC_in   = 32'h0;
    bus.tag_in   = 4'h0;
    bus.bubble   = 1'b1;
    bus.jump     = 1'b0;

    // Reset
    repeat (3) tick();
    check_dec("reset", I_type, adder, OP0, 1'b0, 32'h00000013);
    check("reset.tag", 32'(bus.tag_out), 32'h0);
    check("reset.npc", bus.NPC_out, 32'h0);
    reset = 1'b1;

    // sub a0,a0,a1
    bus.instr_in = 32'h40B50533;
    bus.NPC_in   = 32'h104;
    bus.tag_in   = 4'h1;
    tick();
    check_dec("sub", R_type, adder, OP1, 1'b0, 32'h40B50533);
    check("sub.npc", bus.NPC_out, 32'h104);
    check("sub.tag", 32'(bus.tag_out), 32'h1);

    // sw held through a 4-cycle stall
    bus.instr_in = 32'h00A12023;
    bus.NPC_in   = 32'h108;
    bus.tag_in   = 4'h2;
    tick();
    check_dec("sw", S_type, memory, OP7, 1'b0, 32'h00A12023);
    bus.bubble = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.instr_in = 32'h40B50533 + 32'(i * 128);
      bus.NPC_in   = 32'h200 + 32'(i * 4);
      bus.tag_in   = 4'(i + 7);
      tick();
      check_dec($sformatf("hold%0d", i), S_type, memory, OP7, 1'b0, 32'h00A12023);
      check($sformatf("hold%0d.npc", i), bus.NPC_out, 32'h108);
      check($sformatf("hold%0d.tag", i), 32'(bus.tag_out), 32'h2);
    end
    bus.bubble   = 1'b1;
    bus.instr_in = 32'h00A50513;
    bus.NPC_in   = 32'h10C;
    bus.tag_in   = 4'h4;
    tick();
    check_dec("release", I_type, adder, OP0, 1'b0, 32'h00A50513);
    check("release.npc", bus.NPC_out, 32'h10C);

    // Flush wins over stall
    bus.jump     = 1'b1;
    bus.bubble   = 1'b0;
    bus.tag_in   = 4'h3;
    bus.instr_in = 32'h40B50533;
    bus.NPC_in   = 32'h300;
    tick();
    check_dec("flush", I_type, adder, OP0, 1'b0, 32'h00000013);
    check("flush.tag", 32'(bus.tag_out), 32'h3);
    check("flush.npc", bus.NPC_out, 32'h0);
    bus.jump   = 1'b0;
    bus.bubble = 1'b1;

    ivec("ecall", 32'h00000073);

    vec("lui",   7'b0110111, 3'b000, 7'h00, U_type, bypass,  OP1);
    vec("auipc", 7'b0010111, 3'b000, 7'h00, U_type, adder,   OP0);
    vec("jal",   7'b1101111, 3'b000, 7'h00, J_type, branch,  OP6);
    vec("jalr",  7'b1100111, 3'b000, 7'h00, I_type, branch,  OP7);
    vec("beq",   7'b1100011, 3'b000, 7'h00, B_type, branch,  OP0);
    vec("bne",   7'b1100011, 3'b001, 7'h00, B_type, branch,  OP1);
    vec("blt",   7'b1100011, 3'b100, 7'h00, B_type, branch,  OP2);
    vec("bge",   7'b1100011, 3'b101, 7'h00, B_type, branch,  OP3);
    vec("bltu",  7'b1100011, 3'b110, 7'h00, B_type, branch,  OP4);
    vec("bgeu",  7'b1100011, 3'b111, 7'h00, B_type, branch,  OP5);
    vec("lb",    7'b0000011, 3'b000, 7'h00, I_type, memory,  OP0);
    vec("lbu",   7'b0000011, 3'b100, 7'h00, I_type, memory,  OP1);
    vec("lh",    7'b0000011, 3'b001, 7'h00, I_type, memory,  OP2);
    vec("lhu",   7'b0000011, 3'b101, 7'h00, I_type, memory,  OP3);
    vec("lw",    7'b0000011, 3'b010, 7'h00, I_type, memory,  OP4);
    vec("sb",    7'b0100011, 3'b000, 7'h00, S_type, memory,  OP5);
    vec("sh",    7'b0100011, 3'b001, 7'h00, S_type, memory,  OP6);
    vec("sw2",   7'b0100011, 3'b010, 7'h00, S_type, memory,  OP7);
    vec("addi",  7'b0010011, 3'b000, 7'h20, I_type, adder,   OP0);
    vec("slti",  7'b0010011, 3'b010, 7'h00, I_type, adder,   OP2);
    vec("sltiu", 7'b0010011, 3'b011, 7'h00, I_type, adder,   OP3);
    vec("xori",  7'b0010011, 3'b100, 7'h00, I_type, logical, OP0);
    vec("ori",   7'b0010011, 3'b110, 7'h00, I_type, logical, OP1);
    vec("andi",  7'b0010011, 3'b111, 7'h00, I_type, logical, OP2);
    vec("slli",  7'b0010011, 3'b001, 7'h00, I_type, shifter, OP0);
    vec("srli",  7'b0010011, 3'b101, 7'h00, I_type, shifter, OP1);
    vec("srai",  7'b0010011, 3'b101, 7'h20, I_type, shifter, OP2);
    vec("add",   7'b0110011, 3'b000, 7'h00, R_type, adder,   OP0);
    vec("sub2",  7'b0110011, 3'b000, 7'h20, R_type, adder,   OP1);
    vec("sll",   7'b0110011, 3'b001, 7'h00, R_type, shifter, OP0);
    vec("slt",   7'b0110011, 3'b010, 7'h00, R_type, adder,   OP2);
    vec("sltu",  7'b0110011, 3'b011, 7'h00, R_type, adder,   OP3);
    vec("xor",   7'b0110011, 3'b100, 7'h00, R_type, logical, OP0);
    vec("srl",   7'b0110011, 3'b101, 7'h00, R_type, shifter, OP1);
    vec("sra",   7'b0110011, 3'b101, 7'h20, R_type, shifter, OP2);
    vec("or",    7'b0110011, 3'b110, 7'h00, R_type, logical, OP1);
    vec("and",   7'b0110011, 3'b111, 7'h00, R_type, logical, OP2);

    ivec("bad_load",  {7'h00, 5'd3, 5'd2, 3'b011, 5'd1, 7'b0000011});
    ivec("bad_br",    {7'h00, 5'd3, 5'd2, 3'b010, 5'd1, 7'b1100011});
    ivec("bad_store", {7'h00, 5'd3, 5'd2, 3'b011, 5'd1, 7'b0100011});
    ivec("slli_b25",  {7'h01, 5'd3, 5'd2, 3'b001, 5'd1, 7'b0010011});
    ivec("xor_f7",    {7'h20, 5'd3, 5'd2, 3'b100, 5'd1, 7'b0110011});
    ivec("add_f7",    {7'h01, 5'd3, 5'd2, 3'b000, 5'd1, 7'b0110011});
    ivec("fence",     32'h0000000F);
    for (int i = 0; i < 8; i++) begin
      do opc = 7'($urandom_range(0, 127));
      while (opc inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33});
      w      = $urandom;
      w[6:0] = opc;
      ivec($sformatf("rand%0d", i), w);
    end

    // Reset asserted in the middle of a stall
    bus.instr_in = 32'h40B50533;
    bus.NPC_in   = 32'h400;
    bus.tag_in   = 4'h9;
    tick();
    bus.bubble = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_dec("midrst", I_type, adder, OP0, 1'b0, 32'h00000013);
    check("midrst.npc", bus.NPC_out, 32'h0);
    check("midrst.tag", 32'(bus.tag_out), 32'h0);
    tick();
    reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
